sat_result_sequencer: RTL and testbench

//  Downstream consumer of the 3-SAT solver stage. Samples each evaluated
//  (assignment, CNF result) pair, builds an 8-entry satisfying-assignment
//  map, then reports the verdict on RGB and steps the LEDs through every

---
 rtl/sat_result_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_sat_result_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sat_result_sequencer.sv
// sat_result_sequencer
//   Consumes evaluated (assignment, CNF result) pairs from the 3-SAT solver
//   stage, builds a map of which assignments satisfy the CNF, then reports
//   the verdict on RGB and cycles LED through every satisfying assignment,
//   one per display period. Any change on sel restarts the scan.
//
// Parameters
//   NUM_VARS       variables per assignment; map depth is 2**NUM_VARS
//   DISPLAY_TICKS  clk cycles each satisfying assignment is shown (>= 2)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   sel        in   [1:0] CNF select; any change restarts the scan
//   sol_valid  in   one-cycle strobe qualifying solution/sat
//   solution   in   [NUM_VARS-1:0] assignment evaluated, {A,B,C}
//   sat        in   CNF result for solution (1 = satisfied)
//   RGB        out  [2:0] {R,G,B}: 001 scanning, 010 SAT, 100 UNSAT
//   LED        out  [NUM_VARS-1:0] satisfying assignment being displayed
//   sat_count  out  [NUM_VARS:0] number of satisfying assignments
//   scan_done  out  high once every assignment has been seen
module sat_result_sequencer #(
  parameter int unsigned NUM_VARS      = 3,
  parameter int unsigned DISPLAY_TICKS = 100_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          sel,
  input  logic                sol_valid,
  input  logic [NUM_VARS-1:0] solution,
  input  logic                sat,
  output logic [2:0]          RGB,
  output logic [NUM_VARS-1:0] LED,
  output logic [NUM_VARS:0]   sat_count,
  output logic                scan_done
);

  localparam int unsigned DEPTH = 2 ** NUM_VARS;
  localparam int unsigned TW    = (DISPLAY_TICKS > 1) ? $clog2(DISPLAY_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DISPLAY_TICKS - 1);

  localparam logic [2:0] RGB_SCAN  = 3'b001;
  localparam logic [2:0] RGB_SAT   = 3'b010;
  localparam logic [2:0] RGB_UNSAT = 3'b100;

  typedef enum logic [1:0] {
    SCAN,
    EVAL,
    SHOW,
    NONE
  } state_t;

  state_t               state_q, state_d;
  logic [DEPTH-1:0]     sat_map_q, sat_map_d;
  logic [DEPTH-1:0]     seen_map_q, seen_map_d;
  logic [1:0]           sel_q;
  logic                 sel_vld_q;
  logic [TW-1:0]        tick_q, tick_d;
  logic [NUM_VARS-1:0]  idx_q, idx_d;
  logic [2:0]           rgb_q, rgb_d;
  logic [NUM_VARS-1:0]  led_q, led_d;
  logic [NUM_VARS:0]    sat_count_q, sat_count_d;
  logic                 scan_done_q, scan_done_d;
  logic                 restart;

  function automatic logic [NUM_VARS:0] popcount(input logic [DEPTH-1:0] m);
    logic [NUM_VARS:0] c;
    c = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      c += (NUM_VARS + 1)'(m[k]);
    end
    return c;
  endfunction

  // Next set index strictly above cur, wrapping; returns cur itself when it
  // is the only set bit. Passing cur = all-ones yields the lowest set index.
  function automatic logic [NUM_VARS-1:0] next_set(input logic [DEPTH-1:0]    m,
                                                   input logic [NUM_VARS-1:0] cur);
    logic [NUM_VARS-1:0] r;
    logic [NUM_VARS-1:0] j;
    logic                found;
    r     = cur;
    found = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      j = cur + k[NUM_VARS-1:0];
      if (!found && m[j]) begin
        r     = j;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // sel_q is not loaded asynchronously from sel; instead the compare is
  // suppressed on the first edge after reset, which is when sel_q captures
  // the sel value present at reset release.
  assign restart = sel_vld_q && (sel != sel_q);

  always_comb begin
    state_d     = state_q;
    sat_map_d   = sat_map_q;
    seen_map_d  = seen_map_q;
    tick_d      = tick_q;
    idx_d       = idx_q;
    sat_count_d = sat_count_q;
    scan_done_d = scan_done_q;
    rgb_d       = RGB_SCAN;
    led_d       = '0;

    // Outputs follow the current state/idx, so they lag them by one cycle.
    case (state_q)
      SHOW: begin
        rgb_d = RGB_SAT;
        led_d = idx_q;
      end
      NONE: rgb_d = RGB_UNSAT;
      default: begin
        rgb_d = RGB_SCAN;
        led_d = '0;
      end
    endcase

    case (state_q)
      SCAN: begin
        if (sol_valid) begin
          sat_map_d[solution]  = sat;
          seen_map_d[solution] = 1'b1;
        end
        if (seen_map_d == '1) state_d = EVAL;
      end
      EVAL: begin
        sat_count_d = popcount(sat_map_q);
        scan_done_d = 1'b1;
        if (|sat_map_q) begin
          state_d = SHOW;
          idx_d   = next_set(sat_map_q, '1);
          tick_d  = '0;
        end else begin
          state_d = NONE;
        end
      end
      SHOW: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          idx_d  = next_set(sat_map_q, idx_q);
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Restart overrides everything above, including a coincident sample.
    if (restart) begin
      state_d     = SCAN;
      sat_map_d   = '0;
      seen_map_d  = '0;
      tick_d      = '0;
      idx_d       = '0;
      sat_count_d = '0;
      scan_done_d = 1'b0;
      rgb_d       = RGB_SCAN;
      led_d       = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      sat_map_q   <= '0;
      seen_map_q  <= '0;
      sel_q       <= '0;
      sel_vld_q   <= 1'b0;
      tick_q      <= '0;
      idx_q       <= '0;
      rgb_q       <= RGB_SCAN;
      led_q       <= '0;
      sat_count_q <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sat_map_q   <= sat_map_d;
      seen_map_q  <= seen_map_d;
      sel_q       <= sel;
      sel_vld_q   <= 1'b1;
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      rgb_q       <= rgb_d;
      led_q       <= led_d;
      sat_count_q <= sat_count_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign RGB       = rgb_q;
  assign LED       = led_q;
  assign sat_count = sat_count_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_sat_result_sequencer.sv
module tb_sat_result_sequencer;

  logic       clk;
  logic       reset;
  logic [1:0] sel;
  logic       sol_valid;
  logic [2:0] solution;
  logic       sat;
  logic [2:0] RGB;
  logic [2:0] LED;
  logic [3:0] sat_count;
  logic       scan_done;

  int checks   = 0;
  int failures = 0;

  sat_result_sequencer #(
    .NUM_VARS      (3),
    .DISPLAY_TICKS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .sol_valid (sol_valid),
    .solution  (solution),
    .sat       (sat),
    .RGB       (RGB),
    .LED       (LED),
    .sat_count (sat_count),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [2:0] s, input logic v);
    sol_valid = 1'b1;
    solution  = s;
    sat       = v;
    tick(1);
    sol_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [2:0] exp_led;
    reset = 1'b1; sel = 2'b00; sol_valid = 1'b0; solution = '0; sat = 1'b0;
    #12;
    chk("rst_rgb", 32'(RGB), 32'h1);
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_cnt", 32'(sat_count), 32'h0);
    chk("rst_done", 32'(scan_done), 32'h0);
    reset = 1'b0;
    tick(1);

    // Satisfying set {3,6}
    for (int i = 0; i < 8; i++) feed(3'(i), (i == 3) || (i == 6));
    tick(1);
    chk("t2_cnt", 32'(sat_count), 32'h2);
    chk("t2_done", 32'(scan_done), 32'h1);
    chk("t2_rgb_lag", 32'(RGB), 32'h1);
    tick(1);
    for (int i = 0; i < 12; i++) begin
      exp_led = (i < 4 || i >= 8) ? 3'd3 : 3'd6;
      chk("t2_led", 32'(LED), 32'(exp_led));
      chk("t2_rgb", 32'(RGB), 32'h2);
      tick(1);
    end

    // Asynchronous reset in the middle of SHOW
    reset = 1'b1;
    #1;
    chk("t1_rgb", 32'(RGB), 32'h1);
    chk("t1_led", 32'(LED), 32'h0);
    chk("t1_cnt", 32'(sat_count), 32'h0);
    chk("t1_done", 32'(scan_done), 32'h0);
    #3;
    reset = 1'b0;
    tick(1);

    // All unsatisfied
    for (int i = 0; i < 8; i++) feed(3'(i), 1'b0);
    tick(1);
    chk("t3_cnt", 32'(sat_count), 32'h0);
    chk("t3_done", 32'(scan_done), 32'h1);
    tick(1);
    chk("t3_rgb", 32'(RGB), 32'h4);
    chk("t3_led", 32'(LED), 32'h0);
    tick(3);
    chk("t3_rgb_hold", 32'(RGB), 32'h4);

    // Last value wins; out-of-order feed
    pulse_reset();
    feed(3'd5, 1'b1);
    feed(3'd5, 1'b0);
    feed(3'd7, 1'b0); feed(3'd0, 1'b0); feed(3'd3, 1'b0);
    feed(3'd1, 1'b0); feed(3'd2, 1'b0); feed(3'd4, 1'b0);
    tick(1);
    chk("t4_notdone", 32'(scan_done), 32'h0);
    chk("t4_scan_rgb", 32'(RGB), 32'h1);
    feed(3'd6, 1'b0);
    tick(1);
    chk("t4_done", 32'(scan_done), 32'h1);
    chk("t4_cnt", 32'(sat_count), 32'h0);
    tick(1);
    chk("t4_rgb", 32'(RGB), 32'h4);

    // Restart from SHOW via sel, then all satisfied
    pulse_reset();
    for (int i = 0; i < 8; i++) feed(3'(i), (i == 3) || (i == 6));
    tick(3);
    chk("t5_pre_rgb", 32'(RGB), 32'h2);
    sel = 2'b01;
    tick(1);
    chk("t5_rst_rgb", 32'(RGB), 32'h1);
    chk("t5_rst_done", 32'(scan_done), 32'h0);
    chk("t5_rst_cnt", 32'(sat_count), 32'h0);
    chk("t5_rst_led", 32'(LED), 32'h0);
    for (int i = 0; i < 8; i++) feed(3'(i), 1'b1);
    tick(1);
    chk("t5_cnt", 32'(sat_count), 32'h8);
    tick(1);
    for (int i = 0; i < 33; i++) begin
      exp_led = 3'((i / 4) % 8);
      chk("t5_led", 32'(LED), 32'(exp_led));
      tick(1);
    end
    chk("t5_rgb", 32'(RGB), 32'h2);

    // Sample coincident with a sel change is dropped
    sel = 2'b10;
    tick(1);
    sel = 2'b11;
    feed(3'd7, 1'b1);
    for (int i = 0; i < 7; i++) feed(3'(i), 1'b0);
    tick(1);
    chk("t6_notdone", 32'(scan_done), 32'h0);
    chk("t6_scan_rgb", 32'(RGB), 32'h1);
    feed(3'd7, 1'b1);
    tick(1);
    chk("t6_cnt", 32'(sat_count), 32'h1);
    chk("t6_done", 32'(scan_done), 32'h1);
    tick(1);
    chk("t6_rgb", 32'(RGB), 32'h2);
    chk("t6_led", 32'(LED), 32'h7);
    tick(6);
    chk("t6_led_steady", 32'(LED), 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
